// File: rtl/bcd_key_pkg.sv
// Shared types and helpers for the debounced 10-line-to-BCD key encoder.
// Holds the FSM state type and the priority encoder used by the top level.
package bcd_key_pkg;

    localparam int BCD_W     = 4;
    localparam int NUM_LINES = 10;
    localparam int DB_W      = 8;

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    typedef struct packed {
        logic [BCD_W-1:0] code;
        logic             multi;
    } enc_t;

    // Line 0 has the highest priority; multi flags more than one low line.
    function automatic enc_t prio_encode(
        input logic [NUM_LINES-1:0] lines_n
    );
        enc_t       r;
        logic [3:0] n_low;
        r     = '0;
        n_low = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (!lines_n[i]) begin
                r.code = BCD_W'(i);
                n_low  = n_low + 4'd1;
            end
        end
        r.multi = (n_low > 4'd1);
        return r;
    endfunction

endpackage

// File: rtl/bcd_code_fifo.sv
// First-word-fall-through FIFO for BCD codes, power-of-two depth.
// A pop frees its slot for a push in the same cycle, even when full.
module bcd_code_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bcd_key_encoder.sv
// Synchronized, debounced 10-line-to-BCD encoder with one code per press.
// Codes are queued in a small FWFT FIFO drained through valid/ready.
module bcd_key_encoder
    import bcd_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [9:0]                    lines_n,
    output logic [3:0]                    code_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          multi_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

    logic [NUM_LINES-1:0] sync1_q;
    logic [NUM_LINES-1:0] sync2_q;
    logic [NUM_LINES-1:0] prev_q;
    logic [NUM_LINES-1:0] stable_q, stable_d;
    logic [DB_W-1:0]      cnt_q, cnt_d;
    state_e               state_q, state_d;
    logic                 overflow_q, overflow_d;

    enc_t                 enc;
    logic                 idle_pat;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    // cnt counts consecutive identical synchronized samples.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != prev_q) begin
            cnt_d = DB_W'(1);
        end else if (cnt_q != DB_MAX) begin
            cnt_d = cnt_q + DB_W'(1);
        end
        if (cnt_d == DB_MAX) begin
            stable_d = sync2_q;
        end
    end

    assign enc      = prio_encode(stable_q);
    assign idle_pat = &stable_q;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        multi_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!idle_pat) begin
                    push    = 1'b1;
                    multi_o = enc.multi;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (idle_pat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop        = valid_o & ready_i;
    assign overflow_d = overflow_q | (push & fifo_full & ~pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            prev_q     <= '1;
            stable_q   <= '1;
            cnt_q      <= '0;
            state_q    <= IDLE;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= lines_n;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    bcd_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BCD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (enc.code),
        .pop_i   (pop),
        .data_o  (code_o),
        .count_o (count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign valid_o    = ~fifo_empty;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bcd_key_encoder.sv
// Scenario bench for bcd_key_encoder: directed timing cases plus a
// randomized press sequence scored against a code-queue model.
module tb_bcd_key_encoder;

    localparam int DB    = 4;
    localparam int DEPTH = 4;
    localparam int LAT   = DB + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] lines_n = '1;
    logic       ready_i = 1'b0;
    logic [3:0] code_o;
    logic       valid_o;
    logic       multi_o;
    logic       overflow_o;
    logic [2:0] count_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    bcd_key_encoder #(
        .DEBOUNCE_CYCLES (DB),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lines_n    (lines_n),
        .code_o     (code_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .multi_o    (multi_o),
        .overflow_o (overflow_o),
        .count_o    (count_o)
    );

    // Model: line 0 wins; multi when more than one line is low.
    function automatic int ref_code(input logic [9:0] p);
        for (int i = 0; i < 10; i++) begin
            if (!p[i]) return i;
        end
        return 0;
    endfunction

    function automatic bit ref_multi(input logic [9:0] p);
        return $countones(~p) > 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n   = 1'b0;
        lines_n = '1;
        ready_i = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic press(input int k);
        lines_n = 10'h3FF ^ (10'd1 << k);
        tick(LAT + 2);
        lines_n = '1;
        tick(LAT + 2);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        lines_n = '1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            n_checks++;
            if ({code_o, valid_o, multi_o, overflow_o, count_o} !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got code=%0d v=%b m=%b ov=%b cnt=%0d, expected all 0",
                         code_o, valid_o, multi_o, overflow_o, count_o);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_checks++;
            if (valid_o !== 1'b0 || count_o !== 3'd0) begin
                n_fail++;
                $display("FAIL post_reset_idle: got v=%b cnt=%0d, expected 0 0",
                         valid_o, count_o);
            end
        end
    endtask

    task automatic test_single_press;
        lines_n = 10'h3F7;
        tick(LAT - 1);
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got valid=%b at edge %0d, expected 0",
                     valid_o, LAT - 1);
        end
        tick(1);
        n_checks++;
        if (valid_o !== 1'b1 || code_o !== 4'd3) begin
            n_fail++;
            $display("FAIL latency_edge: got v=%b code=%0d, expected v=1 code=3",
                     valid_o, code_o);
        end
        lines_n = '1;
        tick(LAT + 2);
        lines_n = 10'h1FF;
        tick(LAT + 1);
        n_checks++;
        if (count_o !== 3'd2 || code_o !== 4'd3) begin
            n_fail++;
            $display("FAIL two_codes: got cnt=%0d head=%0d, expected 2 3",
                     count_o, code_o);
        end
        lines_n = '1;
        ready_i = 1'b1;
        tick(1);
        n_checks++;
        if (code_o !== 4'd9 || count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL pop_first: got head=%0d cnt=%0d, expected 9 1",
                     code_o, count_o);
        end
        tick(1);
        ready_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || code_o !== 4'd0 || count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL pop_empty: got v=%b code=%0d cnt=%0d, expected 0 0 0",
                     valid_o, code_o, count_o);
        end
        tick(LAT + 2);
    endtask

    task automatic test_multi;
        lines_n = 10'h3D6;
        tick(LAT - 2);
        n_checks++;
        if (multi_o !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_early: got %b, expected 0", multi_o);
        end
        tick(1);
        n_checks++;
        if (multi_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_pulse: got m=%b v=%b, expected m=1 v=0",
                     multi_o, valid_o);
        end
        tick(1);
        n_checks++;
        if (multi_o !== 1'b0 || valid_o !== 1'b1 || code_o !== 4'd0) begin
            n_fail++;
            $display("FAIL multi_code: got m=%b v=%b code=%0d, expected 0 1 0",
                     multi_o, valid_o, code_o);
        end
        lines_n = 10'h3DF;
        for (int i = 0; i < LAT + 3; i++) begin
            tick(1);
            n_checks++;
            if (multi_o !== 1'b0 || count_o !== 3'd1) begin
                n_fail++;
                $display("FAIL no_rollover: got m=%b cnt=%0d, expected 0 1",
                         multi_o, count_o);
            end
        end
        lines_n = '1;
        tick(LAT + 2);
        n_checks++;
        if (count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL release_no_push: got cnt=%0d, expected 1", count_o);
        end
    endtask

    task automatic test_glitch;
        lines_n = 10'h37F;
        tick(DB - 1);
        lines_n = '1;
        tick(LAT + 5);
        n_checks++;
        if (valid_o !== 1'b0 || count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL glitch_push: got v=%b cnt=%0d, expected 0 0",
                     valid_o, count_o);
        end
        lines_n = 10'h3FB;
        tick(LAT);
        n_checks++;
        if (valid_o !== 1'b1 || code_o !== 4'd2) begin
            n_fail++;
            $display("FAIL glitch_still_idle: got v=%b code=%0d, expected 1 2",
                     valid_o, code_o);
        end
        lines_n = '1;
        tick(LAT + 2);
    endtask

    task automatic test_overflow;
        for (int k = 1; k <= 4; k++) press(k);
        n_checks++;
        if (count_o !== 3'd4 || overflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill: got cnt=%0d ov=%b, expected 4 0",
                     count_o, overflow_o);
        end
        press(5);
        n_checks++;
        if (count_o !== 3'd4 || overflow_o !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: got cnt=%0d ov=%b, expected 4 1",
                     count_o, overflow_o);
        end
        ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (valid_o !== 1'b1 || code_o !== 4'(k)) begin
                n_fail++;
                $display("FAIL drain_ovf: got v=%b code=%0d, expected 1 %0d",
                         valid_o, code_o, k);
            end
            tick(1);
        end
        ready_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || overflow_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_done: got v=%b ov=%b, expected 0 1",
                     valid_o, overflow_o);
        end
    endtask

    task automatic test_back_to_back;
        int exp_codes[4];
        exp_codes = '{2, 3, 4, 7};
        for (int k = 1; k <= 4; k++) press(k);
        lines_n = 10'h37F;
        tick(LAT - 1);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        n_checks++;
        if (count_o !== 3'd4 || overflow_o !== 1'b0 || code_o !== 4'd2) begin
            n_fail++;
            $display("FAIL full_push_pop: got cnt=%0d ov=%b head=%0d, expected 4 0 2",
                     count_o, overflow_o, code_o);
        end
        lines_n = '1;
        tick(LAT + 2);
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (code_o !== 4'(exp_codes[i])) begin
                n_fail++;
                $display("FAIL b2b_drain: got %0d, expected %0d",
                         code_o, exp_codes[i]);
            end
            tick(1);
        end
        ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_hold;
        lines_n = 10'h3BF;
        tick(LAT + 3);
        rst_n = 1'b0;
        tick(3);
        n_checks++;
        if (valid_o !== 1'b0 || count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_clears: got v=%b cnt=%0d, expected 0 0",
                     valid_o, count_o);
        end
        rst_n = 1'b1;
        tick(LAT - 1);
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_repress_early: got v=%b, expected 0", valid_o);
        end
        tick(1);
        n_checks++;
        if (valid_o !== 1'b1 || code_o !== 4'd6 || count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL rst_repress: got v=%b code=%0d cnt=%0d, expected 1 6 1",
                     valid_o, code_o, count_o);
        end
        tick(10);
        n_checks++;
        if (count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL rst_single: got cnt=%0d, expected 1", count_o);
        end
        lines_n = '1;
        tick(LAT + 2);
    endtask

    task automatic test_random;
        int exp_multi;
        int got_multi;
        int phase_len;
        logic [9:0] mask;
        exp_multi = 0;
        got_multi = 0;
        exp_q.delete();
        for (int p = 0; p < 40; p++) begin
            mask = 10'($urandom_range(1, 1023));
            if ($urandom_range(0, 1) == 0) mask = 10'd1 << $urandom_range(0, 9);
            exp_q.push_back(ref_code(~mask));
            if (ref_multi(~mask)) exp_multi++;
            for (int ph = 0; ph < 2; ph++) begin
                lines_n   = (ph == 0) ? ~mask : '1;
                phase_len = $urandom_range(LAT + 1, LAT + 8);
                for (int c = 0; c < phase_len; c++) begin
                    tick(1);
                    if (multi_o === 1'b1) got_multi++;
                    ready_i = ($urandom_range(0, 3) != 0);
                    if (valid_o === 1'b1 && ready_i) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL rand_extra: got code=%0d, expected none",
                                     code_o);
                        end else begin
                            if (code_o !== 4'(exp_q[0])) begin
                                n_fail++;
                                $display("FAIL rand_code: got %0d, expected %0d",
                                         code_o, exp_q[0]);
                            end
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
        ready_i = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            tick(1);
            if (valid_o === 1'b1) begin
                n_checks++;
                if (code_o !== 4'(exp_q[0])) begin
                    n_fail++;
                    $display("FAIL rand_drain: got %0d, expected %0d",
                             code_o, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        tick(1);
        ready_i = 1'b0;
        n_checks++;
        if (exp_q.size() != 0 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_leftover: got %0d pending v=%b, expected 0 0",
                     exp_q.size(), valid_o);
        end
        n_checks++;
        if (got_multi != exp_multi || overflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_multi: got %0d pulses ov=%b, expected %0d 0",
                     got_multi, overflow_o, exp_multi);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_press();
        do_reset();
        test_multi();
        do_reset();
        test_glitch();
        do_reset();
        test_overflow();
        do_reset();
        test_back_to_back();
        do_reset();
        test_reset_mid_hold();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_key_encoder.md
# bcd_key_encoder

- Registered, debounced 10-line-to-BCD encoder: the inverse of the team's BCD-to-decimal decoder with active-low outputs.
- Accepts ten asynchronous active-low decimal lines (keypad, or decoder-style one-cold bus) and synchronizes and debounces them.
- Produces one 4-bit BCD code per press and buffers codes in a small FIFO drained via valid/ready.
- Sits between external switch/strobe inputs and any BCD consumer in the design.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4, consecutive identical synchronized samples required to accept a new line state (1..255)
- FIFO_DEPTH, 4, code buffer entries (power of two, ≥2)

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous, active-low reset
- lines_n  in  10  asynchronous active-low decimal lines; bit k low = digit k asserted
- code_o  out  4  BCD code at FIFO head (0..9)
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  consumer accepts code_o when valid_o & ready_i
- multi_o  out  1  one-cycle pulse: accepted press had >1 line low
- overflow_o  out  1  sticky: a code was dropped because FIFO was full
- count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Sync: two-flop synchronizer on lines_n; both stages reset to all-ones.
- Debounce: counter restarts whenever the sync output differs from its previous value. When the output holds for DEBOUNCE_CYCLES cycles, it is copied into a stable vector. Stable vector resets to all-ones.
- Encode: lowest-index low bit of the stable vector wins (line 0 highest priority). multi_o pulses if popcount(low bits) > 1.
- FSM, reset state IDLE:
  - IDLE: stable vector ≠ all-ones → push encoded code, pulse multi_o if needed → HOLD.
  - HOLD: no pushes; stable vector == all-ones → IDLE. Changing from one non-idle pattern to another does not push; release required (no autorepeat, no rollover).
- FIFO, first-word-fall-through:
  - valid_o = (count ≠ 0); code_o = head entry, 0 when empty.
  - Pop on valid_o & ready_i.
  - Push when full with no pop: code dropped, overflow_o set. Cleared only by reset.
  - Push and pop in the same cycle: both take effect, count unchanged. This includes the full case, which is not an overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: all state cleared, FIFO emptied. A line still held low after reset counts as a new press after the full latency.

## Timing
- Reset values: code_o=0, valid_o=0, multi_o=0, overflow_o=0, count_o=0, FSM=IDLE.
- Press latency: valid_o rises DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the new lines_n level (lines steady). Default: 7.
- Breakdown: 2 sync + DEBOUNCE_CYCLES debounce + 1 FSM/push register.
- multi_o is asserted in the same cycle the push is registered, one cycle before valid_o rises for that code.
- Release latency: FSM returns to IDLE DEBOUNCE_CYCLES+3 edges after lines return to all-ones.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles have no effect.
- Throughput: ≤1 push per cycle, ≤1 pop per cycle. A pop frees space for a push in the same cycle.

## Structure
- Package bcd_key_pkg:
  - BCD_W=4, NUM_LINES=10
  - state enum {IDLE, HOLD}
  - priority-encode function returning {code, multi}
- Sub-module bcd_code_fifo: parameterized FWFT FIFO with push/pop/count/full/empty.
- The top level holds the sync, debounce, and FSM logic.

## Test plan
- Reset, lines all high → all outputs 0 for 50 cycles. Release rst_n → still idle.
- lines_n=10'h3F7 (line 3) steady; ready_i=0 → valid_o=1, code_o=3 at edge 7. Release, press line 9 → count_o=2, head still 3. Pop twice → codes 3 then 9, valid_o=0.
- lines_n=10'h3D6 (lines 0,3,5 low) → one code 0, multi_o one-cycle pulse. Change to line 5 only while held → no new push.
- 3-cycle low glitch on line 7 (DEBOUNCE_CYCLES=4) → no push, FSM stays IDLE.
- ready_i=0; five separate presses 1,2,3,4,5 → count_o=4, overflow_o=1 after the 5th. Drain yields 1,2,3,4.
- FIFO full, push and pop in the same cycle → count_o stays 4, overflow_o stays 0.
- Hold line 6, assert rst_n=0 for 3 cycles mid-HOLD → FIFO cleared. A single code 6 appears 7 edges after reset release.
